// File: rtl/seq_smul_unit.sv
// Sequential signed multiplier using radix-2 Booth recoding, one step per clock.
// Ports:
//   Clock        - rising-edge clock
//   Reset        - asynchronous active-low reset
//   iStart       - multiply request; accepted in IDLE or DONE
//   iDataA       - signed multiplicand, sampled with iStart
//   iDataB       - signed multiplier, sampled with iStart
//   oBusy        - high while the Booth steps run (CALC)
//   oDone        - one-cycle pulse when the product is valid (DONE)
//   oResultLow   - product bits [WIDTH-1:0]
//   oResultHigh  - product bits [2*WIDTH-1:WIDTH]
module seq_smul_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDataA,
  input  logic [WIDTH-1:0] iDataB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResultLow,
  output logic [WIDTH-1:0] oResultHigh
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  // Accumulator: {high (WIDTH+1 bits), multiplier/low (WIDTH bits), q(-1)}.
  // The extra high bit keeps -2^(W-1) * -2^(W-1) from overflowing mid-step.
  localparam int unsigned ACC_W = 2 * WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;

  logic [WIDTH:0]     hi_c;
  logic [WIDTH:0]     mext_c;
  logic [WIDTH:0]     sum_c;
  logic [ACC_W-1:0]   step_c;

  // One Booth step: recode {Q[0], q(-1)}, add/sub the multiplicand, shift right arithmetically.
  always_comb begin
    hi_c   = acc_q[ACC_W-1:WIDTH+1];
    mext_c = {mcand_q[WIDTH-1], mcand_q};
    case (acc_q[1:0])
      2'b01:   sum_c = hi_c + mext_c;
      2'b10:   sum_c = hi_c - mext_c;
      default: sum_c = hi_c;
    endcase
    step_c = ACC_W'($unsigned($signed({sum_c, acc_q[WIDTH:0]}) >>> 1));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_CALC;
          busy_d  = 1'b1;
          mcand_d = iDataA;
          acc_d   = {(WIDTH + 1)'(0), iDataB, 1'b0};
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        acc_d  = step_c;
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          res_lo_d = step_c[WIDTH:1];
          res_hi_d = step_c[2*WIDTH:WIDTH+1];
        end
      end
      S_DONE: begin
        // A start here is a back-to-back request; the completing pulse is already out.
        if (iStart) begin
          state_d = S_CALC;
          busy_d  = 1'b1;
          mcand_d = iDataA;
          acc_d   = {(WIDTH + 1)'(0), iDataB, 1'b0};
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oResultLow  = res_lo_q;
  assign oResultHigh = res_hi_q;

endmodule

// File: tb/tb_seq_smul_unit.sv
// Self-checking bench for seq_smul_unit against a plain-arithmetic product model.
module tb_seq_smul_unit;

  localparam int unsigned WIDTH = 16;

  logic             Clock;
  logic             Reset;
  logic             iStart;
  logic [WIDTH-1:0] iDataA;
  logic [WIDTH-1:0] iDataB;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oResultLow;
  logic [WIDTH-1:0] oResultHigh;

  int checks = 0;
  int errors = 0;

  seq_smul_unit #(.WIDTH(WIDTH)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iStart      (iStart),
    .iDataA      (iDataA),
    .iDataB      (iDataB),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oResultLow  (oResultLow),
    .oResultHigh (oResultHigh)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: exact signed product.
  function automatic logic [31:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = a;
    sb = b;
    return 32'(longint'(sa) * longint'(sb));
  endfunction

  // Present operands with iStart for exactly one rising edge (E0).
  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    @(negedge Clock);
    iStart = 1'b1;
    iDataA = a;
    iDataB = b;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    iDataA = 16'($urandom);
    iDataB = 16'($urandom);
  endtask

  // Count negedges after E0 until oDone (index 0 = first negedge after E0); scramble operands meanwhile.
  task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
    lat = -1;
    busy_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (oDone === 1'b1) begin
        lat = i;
        ok = 1'b1;
        break;
      end
      if (oBusy === 1'b1) busy_cnt++;
      iDataA = 16'($urandom);
      iDataB = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    iStart = 1'b0;
    iDataA = '0;
    iDataB = '0;
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", oBusy); end
    checks++;
    if (oDone !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", oDone); end
    checks++;
    if ({oResultHigh, oResultLow} !== 32'h0) begin
      errors++; $display("FAIL reset_result got=%h want=00000000", {oResultHigh, oResultLow});
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b done=%b want=0/0", oBusy, oDone);
    end
  endtask

  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b);
    int lat;
    int bc;
    bit ok;
    logic [31:0] exp;
    exp = model_mul(a, b);
    do_start(a, b);
    wait_done(lat, bc, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_timeout no oDone within 40 cycles", name);
      return;
    end
    checks++;
    if (lat != 16) begin errors++; $display("FAIL %s_latency got=%0d want=16", name, lat); end
    checks++;
    if (bc != 16) begin errors++; $display("FAIL %s_busy_cycles got=%0d want=16", name, bc); end
    checks++;
    if ({oResultHigh, oResultLow} !== exp) begin
      errors++; $display("FAIL %s_result a=%h b=%h got=%h want=%h", name, a, b, {oResultHigh, oResultLow}, exp);
    end
    @(negedge Clock);
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      errors++; $display("FAIL %s_pulse done=%b busy=%b want=0/0", name, oDone, oBusy);
    end
    repeat (2) @(negedge Clock);
    checks++;
    if ({oResultHigh, oResultLow} !== exp) begin
      errors++; $display("FAIL %s_hold got=%h want=%h", name, {oResultHigh, oResultLow}, exp);
    end
  endtask

  task automatic test_directed();
    run_one("d_3x5", 16'd3, 16'd5);
    run_one("d_m1x1", 16'hFFFF, 16'h0001);
    run_one("d_minxmin", 16'h8000, 16'h8000);
    run_one("d_maxxmax", 16'h7FFF, 16'h7FFF);
    run_one("d_minxmax", 16'h8000, 16'h7FFF);
    // Spot-check the model on the published values.
    checks++;
    if (model_mul(16'h8000, 16'h7FFF) !== 32'hC000_8000) begin
      errors++; $display("FAIL model_minxmax got=%h want=c0008000", model_mul(16'h8000, 16'h7FFF));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_one("rnd", 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt;
    done_cnt = 0;
    do_start(16'd2, 16'd2);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (i == 4) begin
        iStart = 1'b1; iDataA = 16'd9; iDataB = 16'd9;
      end else begin
        iStart = 1'b0; iDataA = 16'($urandom); iDataB = 16'($urandom);
      end
      if (oDone === 1'b1) begin
        done_cnt++;
        checks++;
        if ({oResultHigh, oResultLow} !== 32'h0000_0004) begin
          errors++; $display("FAIL ignore_result got=%h want=00000004", {oResultHigh, oResultLow});
        end
      end
    end
    iStart = 1'b0;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt); end
    checks++;
    if (oBusy !== 1'b0) begin errors++; $display("FAIL ignore_idle busy=%b want=0", oBusy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    bit ok;
    do_start(16'd6, 16'd7);
    wait_done(lat, bc, ok);
    checks++;
    if (!ok || lat != 16) begin errors++; $display("FAIL b2b_first_latency got=%0d want=16", lat); end
    checks++;
    if ({oResultHigh, oResultLow} !== model_mul(16'd6, 16'd7)) begin
      errors++; $display("FAIL b2b_first_result got=%h want=0000002a", {oResultHigh, oResultLow});
    end
    // Hold iStart while in DONE: new E0 is the edge that leaves DONE.
    iStart = 1'b1;
    iDataA = 16'hFFFE;
    iDataB = 16'h0003;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    checks++;
    if (oBusy !== 1'b1 || oDone !== 1'b0) begin
      errors++; $display("FAIL b2b_restart busy=%b done=%b want=1/0", oBusy, oDone);
    end
    wait_done(lat, bc, ok);
    checks++;
    if (!ok || lat != 16) begin errors++; $display("FAIL b2b_second_latency got=%0d want=16", lat); end
    checks++;
    if ({oResultHigh, oResultLow} !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL b2b_second_result got=%h want=fffffffa", {oResultHigh, oResultLow});
    end
    @(negedge Clock);
  endtask

  task automatic test_reset_mid();
    int lat;
    int bc;
    bit ok;
    logic [31:0] exp;
    do_start(16'd100, 16'd100);
    repeat (8) @(negedge Clock);
    checks++;
    if (oBusy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got=%b want=1", oBusy); end
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || {oResultHigh, oResultLow} !== 32'h0) begin
      errors++; $display("FAIL rmid_async busy=%b done=%b res=%h want=0/0/00000000",
                         oBusy, oDone, {oResultHigh, oResultLow});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (oDone !== 1'b0) begin errors++; $display("FAIL rmid_no_done got=%b want=0", oDone); end
    end
    // Start presented on the same cycle reset releases; its edge must be honoured.
    Reset = 1'b1;
    iStart = 1'b1;
    iDataA = 16'd4;
    iDataB = 16'hFFFC;
    exp = model_mul(16'd4, 16'hFFFC);
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    wait_done(lat, bc, ok);
    checks++;
    if (!ok || lat != 16) begin errors++; $display("FAIL rmid_latency got=%0d want=16", lat); end
    checks++;
    if ({oResultHigh, oResultLow} !== exp) begin
      errors++; $display("FAIL rmid_result got=%h want=%h", {oResultHigh, oResultLow}, exp);
    end
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
